// File: rtl/silvland_dl_pkg.sv
// Shared types and constants for the ROM download router.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the download FSM state enum, the ROM region base addresses and the
// region index type used by the decoder and the top level.
package silvland_dl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HOLD,
    ST_RUN,
    ST_ERR
  } dl_state_e;

  typedef logic [1:0] rgn_t;

  // Region base addresses inside the 16-bit core ROM space.
  localparam logic [15:0] RGN_CPU_BASE  = 16'h0000;
  localparam logic [15:0] RGN_TILE_BASE = 16'h6000;
  localparam logic [15:0] RGN_SPR_BASE  = 16'hA000;
  localparam logic [15:0] RGN_SND_BASE  = 16'hB000;

  // Region indices.
  localparam rgn_t RGN_CPU  = 2'd0;
  localparam rgn_t RGN_TILE = 2'd1;
  localparam rgn_t RGN_SPR  = 2'd2;
  localparam rgn_t RGN_SND  = 2'd3;

  // Width of the saturating accepted-byte counter.
  localparam int CNT_W = 17;

endpackage

// File: rtl/silvland_rgn_dec.sv
// Combinational decode of a core ROM address into its region index.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//
// Ports:
//   addr_i  core ROM byte address
//   rgn_o   region index: CPU, tiles, sprites, sound/PROM
module silvland_rgn_dec
  import silvland_dl_pkg::*;
(
  input  logic [15:0] addr_i,
  output rgn_t        rgn_o
);

  // Regions are contiguous and ascending, so test from the top base down.
  always_comb begin
    rgn_o = RGN_CPU;
    if (addr_i >= RGN_SND_BASE) begin
      rgn_o = RGN_SND;
    end else if (addr_i >= RGN_SPR_BASE) begin
      rgn_o = RGN_SPR;
    end else if (addr_i >= RGN_TILE_BASE) begin
      rgn_o = RGN_TILE;
    end
  end

endmodule

// File: rtl/silvland_dl_router.sv
// Routes the HPS ROM download stream into core ROM writes and sequences core reset.
// Latency: one dn_wr pulse one clk_sys cycle after each rising ioctl_wr edge in LOAD.
// Backpressure: none; the HPS stream is accepted unconditionally at byte-strobe rate.
//
// Optional feature macro: DL_CHECKSUM_EN (adds the byte checksum and its
// comparison against EXPECT_SUM to the good/bad download decision).
//
// Ports:
//   clk_sys, reset                  single clock, synchronous active-high reset
//   ioctl_download/wr/addr/dout     HPS download stream
//   dn_addr, dn_data, dn_wr         registered write port to the core ROMs
//   rgn_sel                         region of the current dn_addr
//   core_reset, dl_done, dl_err     download status / core reset request
//   checksum                        running 16-bit sum of accepted bytes
module silvland_dl_router
  import silvland_dl_pkg::*;
#(
  parameter int          ROM_BYTES   = 49152,
  parameter int          HOLD_CYCLES = 1024,
  parameter logic [15:0] EXPECT_SUM  = 16'h0000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output rgn_t        rgn_sel,
  output logic        core_reset,
  output logic        dl_done,
  output logic        dl_err,
  output logic [15:0] checksum
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(ROM_BYTES);

  dl_state_e          state_q, state_d;
  logic               wr_q;
  logic               armed_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               dn_wr_q;
  logic [15:0]        dn_addr_q;
  logic [7:0]         dn_data_q;

  logic               wr_rise;
  logic               in_load;
  logic               in_range;
  logic               accept;
  logic [CNT_W-1:0]   cnt_inc;
  logic               ovf_upd;
  logic               load_entry;
  logic               sum_ok;
  logic               dl_good;

  // Only the first cycle of a (possibly multi-cycle) byte strobe counts.
  assign wr_rise  = ioctl_wr & ~wr_q;
  assign in_load  = (state_q == ST_LOAD);
  assign in_range = (ioctl_addr < 25'(ROM_BYTES));
  assign accept   = in_load & wr_rise & in_range;

  // Next-count/overflow including a write on the current cycle, so a strobe
  // landing on the same cycle as the download fall is part of the decision.
  assign cnt_inc = (accept && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
  assign ovf_upd = ovf_q | (in_load & wr_rise & ~in_range);

`ifdef DL_CHECKSUM_EN
  logic [15:0] sum_q, sum_d, sum_nxt;

  assign sum_nxt = accept ? (sum_q + {8'h00, ioctl_dout}) : sum_q;
  assign sum_ok  = (sum_nxt == EXPECT_SUM);

  always_comb begin
    sum_d = sum_nxt;
    if (load_entry) begin
      sum_d = '0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign checksum = sum_q;
`else
  logic unused_expect_sum;

  assign unused_expect_sum = ^EXPECT_SUM;
  assign sum_ok            = 1'b1;
  assign checksum          = '0;
`endif

  assign dl_good = (cnt_inc == CNT_FULL) & ~ovf_upd & sum_ok;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    hold_d     = hold_q;
    load_entry = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // armed_q demands download to have been seen low since reset, so a
        // download still asserted across a reset does not restart the load.
        if (ioctl_download && armed_q) begin
          state_d    = ST_LOAD;
          load_entry = 1'b1;
        end
      end
      ST_LOAD: begin
        cnt_d  = cnt_inc;
        ovf_d  = ovf_upd;
        hold_d = '0;
        if (!ioctl_download) begin
          state_d = dl_good ? ST_HOLD : ST_ERR;
        end
      end
      ST_HOLD: begin
        if (ioctl_download) begin
          state_d    = ST_LOAD;
          load_entry = 1'b1;
        end else if (hold_q == HOLD_LAST) begin
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_RUN, ST_ERR: begin
        if (ioctl_download) begin
          state_d    = ST_LOAD;
          load_entry = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load_entry) begin
      cnt_d  = '0;
      ovf_d  = 1'b0;
      hold_d = '0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      wr_q      <= 1'b0;
      armed_q   <= 1'b0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      hold_q    <= '0;
      dn_wr_q   <= 1'b0;
      dn_addr_q <= '0;
      dn_data_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= ioctl_wr;
      armed_q <= armed_q | ~ioctl_download;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      hold_q  <= hold_d;
      dn_wr_q <= accept;
      if (accept) begin
        dn_addr_q <= ioctl_addr[15:0];
        dn_data_q <= ioctl_dout;
      end
    end
  end

  silvland_rgn_dec u_rgn_dec (
    .addr_i (dn_addr_q),
    .rgn_o  (rgn_sel)
  );

  assign dn_wr      = dn_wr_q;
  assign dn_addr    = dn_addr_q;
  assign dn_data    = dn_data_q;
  assign core_reset = (state_q != ST_RUN);
  assign dl_done    = (state_q == ST_HOLD) || (state_q == ST_RUN);
  assign dl_err     = (state_q == ST_ERR);

endmodule

// File: tb/tb_silvland_dl_router.sv
// Directed bench for silvland_dl_router.
// dut_a uses a 64-byte ROM (EXPECT_SUM 0x1234) to keep full downloads short;
// dut_b uses default parameters for region decode and 0xC000 rejection.
module tb_silvland_dl_router;
  import silvland_dl_pkg::*;

`ifdef DL_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;

  logic [15:0] dn_addr_a, dn_addr_b;
  logic [7:0]  dn_data_a, dn_data_b;
  logic        dn_wr_a, dn_wr_b;
  rgn_t        rgn_a, rgn_b;
  logic        core_reset_a, core_reset_b;
  logic        dl_done_a, dl_done_b;
  logic        dl_err_a, dl_err_b;
  logic [15:0] checksum_a, checksum_b;

  int checks = 0;
  int errors = 0;
  int pulses_a = 0;
  int base;

  always #5 clk = ~clk;

  silvland_dl_router #(.ROM_BYTES(64), .HOLD_CYCLES(1024), .EXPECT_SUM(16'h1234)) dut_a (
    .clk_sys(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .dn_addr(dn_addr_a), .dn_data(dn_data_a),
    .dn_wr(dn_wr_a), .rgn_sel(rgn_a), .core_reset(core_reset_a), .dl_done(dl_done_a),
    .dl_err(dl_err_a), .checksum(checksum_a)
  );

  silvland_dl_router dut_b (
    .clk_sys(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .dn_addr(dn_addr_b), .dn_data(dn_data_b),
    .dn_wr(dn_wr_b), .rgn_sel(rgn_b), .core_reset(core_reset_b), .dl_done(dl_done_b),
    .dl_err(dl_err_b), .checksum(checksum_b)
  );

  // Each dn_wr pulse is one cycle wide, so sampling every posedge counts it once.
  always @(posedge clk) begin
    if (dn_wr_a) pulses_a <= pulses_a + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One byte with the strobe held three cycles, then one low cycle.
  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    repeat (3) @(negedge clk);
    ioctl_wr = 1'b0;
    @(negedge clk);
  endtask

  // Bytes 0..n-1 at ascending addresses; all 0x49 except the final one.
  // 63*0x49 + 0x3D = 0x1234.
  task automatic stream(input int n, input logic [7:0] last);
    for (int i = 0; i < n; i++) begin
      wr_byte(25'(i), (i == n - 1) ? last : 8'h49);
    end
  endtask

  task automatic start_dl();
    ioctl_download = 1'b1;
    @(negedge clk);
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    @(negedge clk);
  endtask

  logic [24:0] r_addr [4];
  rgn_t        r_exp  [4];

  initial begin
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    r_addr = '{25'h5FFF, 25'h6000, 25'hAFFF, 25'hB000};
    r_exp  = '{2'd0, 2'd1, 2'd2, 2'd3};
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_dn_wr", dn_wr_a, 0);
    chk("rst_dn_addr", dn_addr_a, 0);
    chk("rst_dn_data", dn_data_a, 0);
    chk("rst_rgn", rgn_a, 0);
    chk("rst_core_reset", core_reset_a, 1);
    chk("rst_done", dl_done_a, 0);
    chk("rst_err", dl_err_a, 0);
    chk("rst_checksum", checksum_a, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Full good download, then exact hold length
    base = pulses_a;
    start_dl();
    stream(64, 8'h3D);
    chk("full_pulses", pulses_a - base, 64);
    chk("full_last_addr", dn_addr_a, 16'h003F);
    chk("full_last_data", dn_data_a, 8'h3D);
    ioctl_download = 1'b0;
    @(negedge clk);
    chk("full_done", dl_done_a, 1);
    chk("full_err", dl_err_a, 0);
    chk("full_checksum", checksum_a, CS_EN ? 16'h1234 : 16'h0000);
    chk("hold_start_core_reset", core_reset_a, 1);
    repeat (1023) @(negedge clk);
    chk("hold_last_core_reset", core_reset_a, 1);
    @(negedge clk);
    chk("run_core_reset", core_reset_a, 0);
    chk("run_done", dl_done_a, 1);

    // Short download (one byte missing) goes to ERR and stays there
    base = pulses_a;
    start_dl();
    chk("reload_core_reset", core_reset_a, 1);
    stream(63, 8'h49);
    end_dl();
    chk("short_pulses", pulses_a - base, 63);
    chk("short_err", dl_err_a, 1);
    chk("short_done", dl_done_a, 0);
    repeat (1500) @(negedge clk);
    chk("short_core_reset", core_reset_a, 1);
    chk("short_err_sticky", dl_err_a, 1);

    // Out-of-range write mid-stream is dropped and flags the download bad
    base = pulses_a;
    start_dl();
    stream(32, 8'h49);
    ioctl_addr = 25'hC000;
    ioctl_dout = 8'h55;
    ioctl_wr   = 1'b1;
    @(negedge clk);
    chk("ovf_no_dn_wr", dn_wr_a, 0);
    repeat (2) @(negedge clk);
    ioctl_wr = 1'b0;
    @(negedge clk);
    for (int i = 32; i < 64; i++) wr_byte(25'(i), (i == 63) ? 8'h3D : 8'h49);
    end_dl();
    chk("ovf_pulses", pulses_a - base, 64);
    chk("ovf_err", dl_err_a, 1);
    chk("ovf_done", dl_done_a, 0);

    // Final strobe coincides with the download fall and still counts
    base = pulses_a;
    start_dl();
    stream(63, 8'h49);
    ioctl_addr     = 25'd63;
    ioctl_dout     = 8'h3D;
    ioctl_wr       = 1'b1;
    ioctl_download = 1'b0;
    @(negedge clk);
    chk("coinc_dn_wr", dn_wr_a, 1);
    chk("coinc_done", dl_done_a, 1);
    chk("coinc_err", dl_err_a, 0);
    repeat (2) @(negedge clk);
    ioctl_wr = 1'b0;
    @(negedge clk);
    chk("coinc_pulses", pulses_a - base, 64);

    // Reset mid-load (aborting HOLD entry first): no writes survive
    start_dl();
    chk("abort_hold_done", dl_done_a, 0);
    stream(10, 8'h49);
    base  = pulses_a;
    reset = 1'b1;
    wr_byte(25'd10, 8'h49);
    wr_byte(25'd11, 8'h49);
    reset = 1'b0;
    wr_byte(25'd12, 8'h49);
    wr_byte(25'd13, 8'h49);
    chk("rstmid_pulses", pulses_a - base, 0);
    chk("rstmid_dn_wr", dn_wr_a, 0);
    chk("rstmid_dn_addr", dn_addr_a, 0);
    chk("rstmid_dn_data", dn_data_a, 0);
    chk("rstmid_rgn", rgn_a, 0);
    chk("rstmid_core_reset", core_reset_a, 1);
    chk("rstmid_done", dl_done_a, 0);
    chk("rstmid_err", dl_err_a, 0);
    chk("rstmid_checksum", checksum_a, 0);
    end_dl();
    @(negedge clk);
    base = pulses_a;
    start_dl();
    stream(64, 8'h3D);
    end_dl();
    chk("rstmid_full_pulses", pulses_a - base, 64);
    chk("rstmid_full_done", dl_done_a, 1);
    repeat (1024) @(negedge clk);
    chk("rstmid_run_core_reset", core_reset_a, 0);

    // Checksum off by one
    start_dl();
    stream(64, 8'h3E);
    end_dl();
    chk("cs_bad_err", dl_err_a, CS_EN);
    chk("cs_bad_done", dl_done_a, !CS_EN);
    chk("cs_bad_checksum", checksum_a, CS_EN ? 16'h1235 : 16'h0000);
    start_dl();
    stream(64, 8'h3D);
    end_dl();
    chk("cs_good_done", dl_done_a, 1);
    chk("cs_good_err", dl_err_a, 0);

    // Region boundaries on the default-size instance
    start_dl();
    for (int i = 0; i < 4; i++) begin
      ioctl_addr = r_addr[i];
      ioctl_dout = 8'(i + 1);
      ioctl_wr   = 1'b1;
      @(negedge clk);
      chk("rgn_dn_wr", dn_wr_b, 1);
      chk("rgn_dn_addr", dn_addr_b, r_addr[i]);
      chk("rgn_sel", rgn_b, r_exp[i]);
      repeat (2) @(negedge clk);
      ioctl_wr = 1'b0;
      @(negedge clk);
    end
    ioctl_addr = 25'hC000;
    ioctl_wr   = 1'b1;
    @(negedge clk);
    chk("c000_no_dn_wr", dn_wr_b, 0);
    repeat (2) @(negedge clk);
    ioctl_wr = 1'b0;
    @(negedge clk);
    chk("c000_addr_kept", dn_addr_b, 16'hB000);
    end_dl();
    chk("c000_err_b", dl_err_b, 1);
    chk("c000_err_a", dl_err_a, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
